// File: rtl/eth_udp_pkg.sv
// Shared types for the UDP transmit path: the UDP/IP header record handed
// to the stack and the state encoding of the transmit arbiter.
package eth_udp_pkg;

  // Header fields in wire order, 144 bits in total.
  typedef struct packed {
    logic [5:0]  ip_dscp;
    logic [1:0]  ip_ecn;
    logic [7:0]  ip_ttl;
    logic [31:0] ip_source_ip;
    logic [31:0] ip_dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [15:0] checksum;
  } udp_hdr_t;

  localparam int UDP_HDR_W = $bits(udp_hdr_t);

  // Arbiter FSM: IDLE picks a winner, HDR forwards the header,
  // PAYLOAD passes beats through until tlast.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } udp_arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Bundle of the requester-side and stack-side header/payload signals of the
// UDP transmit arbiter.
//
// Handshake rule for every channel here (hdr and payload, both sides): a
// transfer happens on a rising clk edge where valid and ready are both high;
// ready may depend combinationally on valid, a source keeps its data stable
// while valid is high and not yet accepted.
interface udp_tx_arbiter_if #(
  parameter int NUM_PORTS   = 2,
  parameter int TUSER_WIDTH = 1
);
  import eth_udp_pkg::*;

  // Requester side, one lane per port.
  logic [NUM_PORTS-1:0]                  s_hdr_valid;
  logic [NUM_PORTS-1:0]                  s_hdr_ready;
  udp_hdr_t [NUM_PORTS-1:0]              s_hdr;
  logic [NUM_PORTS-1:0][7:0]             s_tdata;
  logic [NUM_PORTS-1:0]                  s_tvalid;
  logic [NUM_PORTS-1:0]                  s_tlast;
  logic [NUM_PORTS-1:0][TUSER_WIDTH-1:0] s_tuser;
  logic [NUM_PORTS-1:0]                  s_tready;

  // Stack side, single shared lane.
  logic                   m_hdr_valid;
  logic                   m_hdr_ready;
  udp_hdr_t               m_hdr;
  logic [7:0]             m_tdata;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic [TUSER_WIDTH-1:0] m_tuser;
  logic                   m_tready;

  // View of the arbiter itself.
  modport slave (
    input  s_hdr_valid, s_hdr, s_tdata, s_tvalid, s_tlast, s_tuser,
    input  m_hdr_ready, m_tready,
    output s_hdr_ready, s_tready,
    output m_hdr_valid, m_hdr, m_tdata, m_tvalid, m_tlast, m_tuser
  );

  // View of the surroundings (requesters plus stack).
  modport master (
    output s_hdr_valid, s_hdr, s_tdata, s_tvalid, s_tlast, s_tuser,
    output m_hdr_ready, m_tready,
    input  s_hdr_ready, s_tready,
    input  m_hdr_valid, m_hdr, m_tdata, m_tvalid, m_tlast, m_tuser
  );

endinterface

// File: rtl/udp_tx_arbiter_rr.sv
// Combinational round-robin picker. The search starts at the port after
// `last` and wraps, so the most recent winner has the lowest priority.
// gnt is one-hot (zero when nothing requests); gnt_idx is its index.
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] last,
  output logic [NUM_PORTS-1:0]         gnt,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  // Walk last+1 .. last+NUM_PORTS (mod NUM_PORTS), first requester wins.
  always_comb begin
    int   cand;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter for the shared UDP transmit path.
// A winner's header is registered and offered to the stack, then its
// payload is passed straight through until tlast; only then is the path
// re-arbitrated. Frames are never cut short or interleaved.
module udp_tx_arbiter
  import eth_udp_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int TUSER_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  udp_tx_arbiter_if.slave      bus,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 busy,
  output udp_arb_state_t       state
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2) begin : g_bad_ports
    $error("udp_tx_arbiter needs NUM_PORTS >= 2");
  end

  udp_arb_state_t   state_q, state_d;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] owner_q;
  udp_hdr_t         hdr_q;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 take_hdr;

  logic [NUM_PORTS-1:0]   s_hdr_ready;
  logic [NUM_PORTS-1:0]   s_tready;
  logic                   m_hdr_valid;
  logic [7:0]             m_tdata;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic [TUSER_WIDTH-1:0] m_tuser;

  rr_arbiter #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr (
    .req     (bus.s_hdr_valid),
    .last    (last_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // State, round-robin pointer, current owner and the header register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      owner_q <= '0;
      hdr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (take_hdr) begin
        last_q  <= arb_idx;
        owner_q <= arb_idx;
        hdr_q   <= bus.s_hdr[arb_idx];
      end
    end
  end

  // Next state plus every handshake output; the payload mux is transparent.
  always_comb begin
    state_d     = state_q;
    take_hdr    = 1'b0;
    s_hdr_ready = '0;
    s_tready    = '0;
    m_hdr_valid = 1'b0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = '0;
    case (state_q)
      IDLE: begin
        // Gated by reset so no header is accepted while reset is held.
        if (!reset && (|bus.s_hdr_valid)) begin
          s_hdr_ready = arb_gnt;
          take_hdr    = 1'b1;
          state_d     = HDR;
        end
      end
      HDR: begin
        m_hdr_valid = 1'b1;
        if (bus.m_hdr_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        m_tdata           = bus.s_tdata[owner_q];
        m_tvalid          = bus.s_tvalid[owner_q];
        m_tlast           = bus.s_tlast[owner_q];
        m_tuser           = bus.s_tuser[owner_q];
        s_tready[owner_q] = bus.m_tready;
        if (m_tvalid && bus.m_tready && m_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner as one-hot, empty while idle.
  always_comb begin
    grant = '0;
    if (state_q != IDLE) grant[owner_q] = 1'b1;
  end

  assign busy  = (state_q != IDLE);
  assign state = state_q;

  assign bus.s_hdr_ready = s_hdr_ready;
  assign bus.s_tready    = s_tready;
  assign bus.m_hdr_valid = m_hdr_valid;
  assign bus.m_hdr       = hdr_q;
  assign bus.m_tdata     = m_tdata;
  assign bus.m_tvalid    = m_tvalid;
  assign bus.m_tlast     = m_tlast;
  assign bus.m_tuser     = m_tuser;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter with three requesters: reset values, a table of
// arbitration vectors, hand-written multi-cycle sequences, then randomized
// traffic scored against a frame-level reference model.
module tb_udp_tx_arbiter;
  import eth_udp_pkg::*;

  localparam int NP = 3;
  localparam int TW = 1;
  localparam int BW = TW + 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  udp_tx_arbiter_if #(.NUM_PORTS(NP), .TUSER_WIDTH(TW)) bus ();
  logic [NP-1:0]  grant;
  logic           busy;
  udp_arb_state_t dbg_state;

  udp_tx_arbiter #(.NUM_PORTS(NP), .TUSER_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .grant (grant),
    .busy  (busy),
    .state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic udp_hdr_t hdr_of(input int p);
    udp_hdr_t h;
    h.ip_dscp      = 6'(p + 1);
    h.ip_ecn       = 2'(p);
    h.ip_ttl       = 8'(64 + p);
    h.ip_source_ip = 32'hC0A8_0100 + 32'(p);
    h.ip_dest_ip   = 32'h0A00_0001;
    h.source_port  = 16'(5000 + p);
    h.dest_port    = 16'(1000 + p);
    h.length       = 16'd9;
    h.checksum     = 16'h0;
    return h;
  endfunction

  function automatic udp_hdr_t rand_hdr();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return udp_hdr_t'(r[143:0]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.s_hdr_valid = '0;
    bus.s_tvalid    = '0;
    bus.s_tlast     = '0;
    bus.s_tuser     = '0;
    bus.s_tdata     = '0;
    for (int p = 0; p < NP; p++) bus.s_hdr[p] = hdr_of(p);
    bus.m_hdr_ready = 1'b1;
    bus.m_tready    = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  // ---------------- scoreboard / reference model ----------------
  int ph[NP];
  int bidx[NP];
  int flen[NP];
  logic [7:0]    fdat[NP][8];
  logic [TW-1:0] fusr[NP][8];
  udp_hdr_t      fhdr[NP];
  logic [NP-1:0] hacc, bacc;
  int m_phase, m_last, m_win, cyc, last_tlast_cyc;
  logic [143:0]  exp_hdr_q[$];
  logic [BW-1:0] exp_q[$];
  int win_log[$];
  int gap_log[$];
  int k_start, k_lmin, k_lmax, k_hrdy, k_trdy, k_tval;
  bit drain;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      ph[p] = 0;
      bidx[p] = 0;
      flen[p] = 1;
    end
    hacc = '0;
    bacc = '0;
    m_phase = 0;
    m_last = NP - 1;
    m_win = 0;
    cyc = 0;
    last_tlast_cyc = -1;
    exp_hdr_q.delete();
    exp_q.delete();
    win_log.delete();
    gap_log.delete();
    drain = 1'b0;
  endtask

  // Sample at negedge: model arbitration and score the stack side.
  task automatic eng_sample();
    logic [NP-1:0] oh;
    logic [BW-1:0] beat;
    int w;
    @(negedge clk);
    hacc = bus.s_hdr_valid & bus.s_hdr_ready;
    bacc = bus.s_tvalid & bus.s_tready;
    oh = '0;
    if (m_phase == 0) begin
      check("eng_idle_out", 144'({grant, bus.s_tready, bus.m_tvalid, bus.m_hdr_valid}), 144'(0));
      if (bus.s_hdr_valid != '0) begin
        w = -1;
        for (int k = 1; k <= NP; k++) begin
          int q;
          q = (m_last + k) % NP;
          if (w < 0 && bus.s_hdr_valid[q]) w = q;
        end
        oh[w] = 1'b1;
        check("eng_hdr_ready", 144'(bus.s_hdr_ready), 144'(oh));
        exp_hdr_q.push_back(144'(fhdr[w]));
        for (int b = 0; b < flen[w]; b++)
          exp_q.push_back({fusr[w][b], (b == flen[w] - 1), fdat[w][b]});
        win_log.push_back(w);
        if (last_tlast_cyc >= 0) gap_log.push_back(cyc + 1 - last_tlast_cyc);
        m_last = w;
        m_win = w;
        m_phase = 1;
      end else begin
        check("eng_no_ready", 144'(bus.s_hdr_ready), 144'(0));
      end
    end else begin
      oh[m_win] = 1'b1;
      check("eng_grant", 144'(grant), 144'(oh));
      check("eng_ready_busy", 144'(bus.s_hdr_ready), 144'(0));
      check("eng_other_tready", 144'(bus.s_tready & ~oh), 144'(0));
      if (m_phase == 1) begin
        check("eng_hdr_valid", 144'({bus.m_hdr_valid, bus.m_tvalid}), 144'(2'b10));
        if (exp_hdr_q.size() > 0) begin
          check("eng_hdr", 144'(bus.m_hdr), exp_hdr_q[0]);
          if (bus.m_hdr_ready) begin
            void'(exp_hdr_q.pop_front());
            m_phase = 2;
          end
        end else begin
          check("eng_hdr_q_empty", 144'(1), 144'(0));
        end
      end else begin
        check("eng_tready_pass", 144'(bus.s_tready & oh), 144'(bus.m_tready ? oh : '0));
        if (bus.m_tvalid && bus.m_tready) begin
          if (exp_q.size() > 0) begin
            beat = exp_q.pop_front();
            check("eng_beat", 144'({bus.m_tuser, bus.m_tlast, bus.m_tdata}), 144'(beat));
            if (beat[8]) begin
              m_phase = 0;
              last_tlast_cyc = cyc;
            end
          end else begin
            check("eng_beat_q_empty", 144'(1), 144'(0));
          end
        end
      end
    end
  endtask

  // Drive after posedge: per-port frame sources and stack readiness.
  task automatic eng_drive();
    for (int p = 0; p < NP; p++) begin
      if (ph[p] == 1 && hacc[p]) begin
        ph[p] = 2;
        bidx[p] = 0;
        bus.s_hdr_valid[p] = 1'b0;
        bus.s_tvalid[p] = 1'b0;
      end else if (ph[p] == 2 && bacc[p]) begin
        bidx[p]++;
        bus.s_tvalid[p] = 1'b0;
        if (bidx[p] == flen[p]) ph[p] = 0;
      end
      if (ph[p] == 0 && !drain && $urandom_range(99, 0) < k_start) begin
        flen[p] = $urandom_range(k_lmax, k_lmin);
        for (int b = 0; b < 8; b++) begin
          fdat[p][b] = 8'($urandom());
          fusr[p][b] = TW'($urandom());
        end
        fhdr[p] = rand_hdr();
        bus.s_hdr[p] = fhdr[p];
        bus.s_hdr_valid[p] = 1'b1;
        ph[p] = 1;
      end
      if (ph[p] == 2) begin
        if (!bus.s_tvalid[p]) bus.s_tvalid[p] = ($urandom_range(99, 0) < k_tval);
        bus.s_tdata[p] = fdat[p][bidx[p]];
        bus.s_tlast[p] = (bidx[p] == flen[p] - 1);
        bus.s_tuser[p] = fusr[p][bidx[p]];
      end
    end
    bus.m_hdr_ready = ($urandom_range(99, 0) < k_hrdy);
    bus.m_tready    = ($urandom_range(99, 0) < k_trdy);
  endtask

  task automatic eng_cycle();
    eng_sample();
    step();
    cyc++;
    eng_drive();
  endtask

  task automatic eng_drain();
    int n;
    drain = 1'b1;
    n = 0;
    while (n < 400 && (ph[0] != 0 || ph[1] != 0 || ph[2] != 0 || m_phase != 0)) begin
      eng_cycle();
      n++;
    end
    check("drain_done", 144'({ph[0] != 0, ph[1] != 0, ph[2] != 0, m_phase != 0}), 144'(0));
    check("drain_queues", 144'(exp_hdr_q.size() + exp_q.size()), 144'(0));
  endtask

  // ---------------- arbitration vector table ----------------
  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] exp_ready;
    int            exp_idx;
  } arb_vec_t;
  arb_vec_t vecs[10];

  // ---------------- main sequence ----------------
  initial begin
    udp_hdr_t h1, hb;
    int got, bi;
    bit hs, done;

    // Priority after reset is 0; each line follows from the previous winner.
    vecs[0] = '{3'b111, 3'b001, 0};
    vecs[1] = '{3'b111, 3'b010, 1};
    vecs[2] = '{3'b101, 3'b100, 2};
    vecs[3] = '{3'b110, 3'b010, 1};
    vecs[4] = '{3'b010, 3'b010, 1};
    vecs[5] = '{3'b001, 3'b001, 0};
    vecs[6] = '{3'b100, 3'b100, 2};
    vecs[7] = '{3'b011, 3'b001, 0};
    vecs[8] = '{3'b110, 3'b010, 1};
    vecs[9] = '{3'b101, 3'b100, 2};

    // Reset values.
    reset = 1'b1;
    clear_inputs();
    step();
    @(negedge clk);
    check("rst_state", 144'(dbg_state), 144'(IDLE));
    check("rst_flags", 144'({grant, busy, bus.m_hdr_valid, bus.m_tvalid, bus.m_tlast}), 144'(0));
    check("rst_ready", 144'({bus.s_hdr_ready, bus.s_tready}), 144'(0));
    check("rst_hdr", 144'(bus.m_hdr), 144'(0));
    step();
    reset = 1'b0;

    // Table of arbitration vectors, each followed by a one-beat frame.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      for (int p = 0; p < NP; p++) begin
        bus.s_tdata[p] = 8'h10 + 8'(p);
        bus.s_tuser[p] = TW'(p);
      end
      bus.s_tvalid = '1;
      bus.s_tlast  = '1;
      bus.s_hdr_valid = vecs[i].req;
      @(negedge clk);
      check("tbl_ready", 144'(bus.s_hdr_ready), 144'(vecs[i].exp_ready));
      step();
      bus.s_hdr_valid = '0;
      @(negedge clk);
      check("tbl_hdr", 144'(bus.m_hdr), 144'(hdr_of(vecs[i].exp_idx)));
      check("tbl_grant", 144'(grant), 144'(vecs[i].exp_ready));
      step();
      @(negedge clk);
      check("tbl_beat", 144'({bus.m_tvalid, bus.m_tlast, bus.m_tdata}),
            144'({2'b11, 8'h10 + 8'(vecs[i].exp_idx)}));
      step();
    end
    clear_inputs();

    // Single requester, port 1, four beats.
    do_reset();
    h1 = hdr_of(1);
    h1.dest_port = 16'd1234;
    h1.length = 16'd12;
    bus.s_hdr[1] = h1;
    bus.s_hdr_valid = 3'b010;
    @(negedge clk);
    check("single_ready", 144'({busy, bus.s_hdr_ready}), 144'(4'b0010));
    step();
    bus.s_hdr_valid = '0;
    bus.s_tvalid[1] = 1'b1;
    bus.s_tdata[1] = 8'hA0;
    @(negedge clk);
    check("single_hdr", 144'(bus.m_hdr), 144'(h1));
    check("single_hdr_phase", 144'({bus.m_hdr_valid, bus.m_tvalid, bus.s_tready}), 144'(5'b10000));
    step();
    for (int k = 0; k < 4; k++) begin
      bus.s_tdata[1] = 8'hA0 + 8'(k);
      bus.s_tlast[1] = (k == 3);
      @(negedge clk);
      check("single_beat", 144'({bus.m_tvalid, bus.m_tlast, bus.m_tdata, bus.s_tready}),
            144'({1'b1, (k == 3), 8'hA0 + 8'(k), 3'b010}));
      step();
    end
    bus.s_tvalid = '0;
    @(negedge clk);
    check("single_idle", 144'({dbg_state == IDLE, busy}), 144'(2'b10));
    step();
    clear_inputs();

    // Backpressure: header held 5 cycles, then m_tready toggling.
    do_reset();
    hb = rand_hdr();
    bus.s_hdr[1] = hb;
    bus.s_hdr_valid = 3'b010;
    bus.m_hdr_ready = 1'b0;
    bus.m_tready = 1'b0;
    bus.s_tvalid = 3'b101;
    bus.s_tdata[0] = 8'hEE;
    bus.s_tdata[2] = 8'hEE;
    @(negedge clk);
    check("bp_ready", 144'(bus.s_hdr_ready), 144'(3'b010));
    step();
    bus.s_hdr_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hdr_hold", 144'({bus.m_hdr_valid, bus.m_hdr}), 144'({1'b1, hb}));
      check("bp_no_tready", 144'(bus.s_tready), 144'(0));
      step();
    end
    bus.m_hdr_ready = 1'b1;
    @(negedge clk);
    check("bp_hdr_hs", 144'(bus.m_hdr), 144'(hb));
    step();
    bus.m_hdr_ready = 1'b0;
    bus.s_tvalid[1] = 1'b1;
    bi = 0;
    got = 0;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      bus.m_tready = ~bus.m_tready;
      bus.s_tdata[1] = 8'hC0 + 8'(bi);
      bus.s_tlast[1] = (bi == 4);
      @(negedge clk);
      check("bp_other_tready", 144'({bus.s_tready[0], bus.s_tready[2]}), 144'(0));
      check("bp_tready_pass", 144'(bus.s_tready[1]), 144'(bus.m_tready));
      hs = bus.m_tvalid && bus.m_tready;
      if (hs) begin
        check("bp_beat", 144'({bus.m_tlast, bus.m_tdata}), 144'({(got == 4), 8'hC0 + 8'(got)}));
        got++;
        if (bus.m_tlast) done = 1'b1;
      end
      step();
      if (hs) bi++;
    end
    check("bp_count", 144'(got), 144'(5));
    clear_inputs();

    // Late requester: port 2 appears during port 0's payload.
    do_reset();
    bus.s_hdr_valid = 3'b001;
    @(negedge clk);
    check("late_first", 144'(bus.s_hdr_ready), 144'(3'b001));
    step();
    bus.s_hdr_valid = '0;
    step();
    for (int k = 0; k < 3; k++) begin
      bus.s_tvalid[0] = 1'b1;
      bus.s_tdata[0] = 8'h70 + 8'(k);
      bus.s_tlast[0] = (k == 2);
      if (k == 1) bus.s_hdr_valid[2] = 1'b1;
      @(negedge clk);
      check("late_hold", 144'({bus.s_hdr_ready, bus.m_tdata}), 144'({3'b000, 8'h70 + 8'(k)}));
      step();
    end
    bus.s_tvalid = '0;
    @(negedge clk);
    check("late_grant", 144'(bus.s_hdr_ready), 144'(3'b100));
    step();
    bus.s_hdr_valid = '0;
    bus.s_tvalid[2] = 1'b1;
    bus.s_tlast[2] = 1'b1;
    @(negedge clk);
    check("late_hdr", 144'(bus.m_hdr), 144'(hdr_of(2)));
    step();
    step();
    clear_inputs();

    // Reset during beat 2 of 5.
    do_reset();
    bus.s_hdr_valid = 3'b001;
    step();
    bus.s_hdr_valid = '0;
    step();
    bus.s_tvalid[0] = 1'b1;
    bus.s_tdata[0] = 8'hD0;
    @(negedge clk);
    check("rmid_beat1", 144'(bus.m_tdata), 144'(8'hD0));
    step();
    bus.s_tdata[0] = 8'hD1;
    reset = 1'b1;
    @(negedge clk);
    check("rmid_beat2", 144'(bus.m_tdata), 144'(8'hD1));
    step();
    bus.s_hdr_valid = '1;
    @(negedge clk);
    check("rmid_after", 144'({busy, grant, bus.m_tvalid, bus.m_hdr_valid, bus.s_tready}), 144'(0));
    check("rmid_hdr_ready", 144'(bus.s_hdr_ready), 144'(0));
    check("rmid_hdr_reg", 144'(bus.m_hdr), 144'(0));
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rmid_first", 144'(bus.s_hdr_ready), 144'(3'b001));
    step();
    clear_inputs();

    // Contention: all ports re-request continuously with 2-beat frames.
    do_reset();
    model_reset();
    k_start = 100; k_lmin = 2; k_lmax = 2; k_tval = 100; k_hrdy = 100; k_trdy = 100;
    eng_drive();
    for (int i = 0; i < 100 && win_log.size() < 6; i++) eng_cycle();
    eng_drain();
    check("cont_frames", 144'(win_log.size() >= 6), 144'(1));
    for (int i = 0; i < 6 && i < win_log.size(); i++)
      check("cont_order", 144'(win_log[i]), 144'(i % NP));
    for (int i = 0; i < 5 && i < gap_log.size(); i++)
      check("cont_gap", 144'(gap_log[i]), 144'(2));

    // Randomized traffic against the reference model.
    clear_inputs();
    do_reset();
    model_reset();
    k_start = 30; k_lmin = 1; k_lmax = 6; k_tval = 70; k_hrdy = 60; k_trdy = 60;
    eng_drive();
    for (int i = 0; i < 1500; i++) eng_cycle();
    eng_drain();
    check("rand_frames", 144'(win_log.size() > 20), 144'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
